rs_alu: RTL and testbench
=========================

Name: rs_alu

Overview:
Reservation station that sits between the issue stage and the ALU. It buffers decoded integer operations until both operands are available, snoops the common data bus (CDB) for outstanding ROB tags, and dispatches at most one ready operation per cycle to the ALU. The outputs are the ALU operand and opcode inputs plus the destination ROB tag, which the writeback path uses to broadcast the result. This block is the initiator side of the ALU interface.

Parameters:
RS_SIZE, 8, number of entries (power of two, at least 2)
TAG_W, 4, ROB tag width

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-high reset
rdy_in  input  1  global ready; when low, the block is frozen
flush  input  1  misprediction flush; clears all entries
issue_valid  input  1  new operation presented this cycle
issue_op  input  4  ALU opcode, using the define.v encoding (Add..Requal)
issue_vj  input  32  operand 1 value, valid when issue_qj_busy=0
issue_qj  input  TAG_W  operand 1 producer tag
issue_qj_busy  input  1  operand 1 is still waiting on issue_qj
issue_vk  input  32  operand 2 value
issue_qk  input  TAG_W  operand 2 producer tag
issue_qk_busy  input  1  operand 2 is still waiting on issue_qk
issue_dest  input  TAG_W  destination ROB tag
rs_full  output  1  all entries busy (combinational from the occupancy register)
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_W  CDB tag
cdb_value  input  32  CDB value
alu_valid  output  1  dispatch strobe (registered)
alu_op  output  4  opcode sent to the ALU
alu_op1  output  32  operand 1 sent to the ALU
alu_op2  output  32  operand 2 sent to the ALU
alu_dest  output  TAG_W  destination tag for the result

Behaviour:
- Reset (asynchronous): every entry is set not-busy; alu_valid=0, alu_op=0, alu_op1=0, alu_op2=0, alu_dest=0; rs_full=0.
- All updates happen on the rising edge of clk_in. Priority order: rst_in, then rdy_in low (hold all state and outputs), then flush, then normal operation.
- Flush: all entries become not-busy and alu_valid=0 at that edge. An issue or CDB event in the same cycle is ignored.
- Entry fields: busy, op, vj, qj, qj_busy, vk, qk, qk_busy, dest.
- Issue: when issue_valid=1 and rs_full=0, the lowest-index free entry is written. If issue_valid=1 while rs_full=1, the operation is dropped and existing entries are unchanged.
- Same-cycle bypass: if cdb_valid=1, a qX_busy input is 1, and cdb_tag equals that qX, the entry stores cdb_value and a cleared busy flag for that operand.
- CDB snoop: every busy entry with qj_busy=1 and qj==cdb_tag captures cdb_value into vj and clears qj_busy. The qk operand is handled the same way. Both operands can match the same broadcast.
- Ready condition: busy=1 and qj_busy=0 and qk_busy=0, evaluated on registered state. An operand woken at edge E is first eligible to dispatch at edge E+1.
- Select/dispatch: the lowest-index ready entry is chosen each cycle. At the edge, alu_* are loaded from that entry, alu_valid is set to 1, and the entry is freed. If no entry is ready, alu_valid=0 and the other alu_* outputs hold their values.
- Latency: an operation issued with both operands ready at edge E0 appears on the alu_* outputs after edge E0+1. Minimum issue-to-dispatch latency is one cycle.
- Simultaneous events: issue into a free slot, dispatch from another slot, and a CDB wakeup can all happen in one edge. A slot freed by dispatch at edge E is not reusable until edge E+1, because rs_full and the free-slot choice come from pre-edge state.
- Widths: values are 32 bits. Tags are compared over the full TAG_W width. The opcode passes through unmodified.

Test Plan:
- Reset: pulse rst_in mid-run with 3 busy entries -> outputs are immediately zero (asynchronous), rs_full=0, and no dispatch after release.
- Ready issue: issue Add, vj=5, vk=7, dest=3, both operands ready -> on the next cycle alu_valid=1, alu_op=Add, alu_op1=5, alu_op2=7, alu_dest=3. alu_valid=0 on the cycle after.
- CDB wakeup: issue Sub with qj=2 busy and vk=1 -> no dispatch. Broadcast tag 2, value 10 -> dispatch one cycle later with alu_op1=10, alu_op2=1.
- Bypass: issue with qk=6 busy in the same cycle as cdb tag 6, value 0xFFFF0000 -> dispatch on the next cycle with alu_op2=0xFFFF0000.
- Full: issue 8 ops whose operands wait on tag 9 -> rs_full=1. A 9th issue is dropped. Broadcast tag 9 -> 8 dispatches on consecutive cycles in index order 0..7, then rs_full=0.
- Flush and stall: hold rdy_in=0 across a CDB match -> nothing changes. With 4 waiting entries, assert flush -> all entries freed, alu_valid=0, and a subsequent ready issue dispatches normally.

Source files
------------

// File: rtl/rs_alu_if.sv
// rs_alu_if: dispatch bus from the reservation station to the ALU.
interface rs_alu_if #(
    parameter int TAG_W = 4
) ();
    logic             alu_valid;
    logic [3:0]       alu_op;
    logic [31:0]      alu_op1;
    logic [31:0]      alu_op2;
    logic [TAG_W-1:0] alu_dest;

    modport master (
        output alu_valid, alu_op, alu_op1, alu_op2, alu_dest
    );

    modport slave (
        input alu_valid, alu_op, alu_op1, alu_op2, alu_dest
    );
endinterface

// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station; buffers issued ops, snoops the CDB, dispatches the lowest ready entry.
module rs_alu #(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [3:0]       issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [TAG_W-1:0] issue_qj,
    input  logic             issue_qj_busy,
    input  logic [31:0]      issue_vk,
    input  logic [TAG_W-1:0] issue_qk,
    input  logic             issue_qk_busy,
    input  logic [TAG_W-1:0] issue_dest,
    output logic             rs_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    rs_alu_if.master         alu
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d, qjb_q, qjb_d, qkb_q, qkb_d, ready;
    logic [3:0]         op_q   [RS_SIZE];
    logic [3:0]         op_d   [RS_SIZE];
    logic [31:0]        vj_q   [RS_SIZE];
    logic [31:0]        vj_d   [RS_SIZE];
    logic [31:0]        vk_q   [RS_SIZE];
    logic [31:0]        vk_d   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_d   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic             alu_valid_q, alu_valid_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [31:0]      alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
    logic [TAG_W-1:0] alu_dest_q, alu_dest_d;

    logic [IDX_W-1:0] free_idx, rdy_idx;
    logic             has_rdy, byp_j, byp_k;

    assign ready   = busy_q & ~qjb_q & ~qkb_q;
    assign has_rdy = |ready;
    assign rs_full = &busy_q;
    assign byp_j   = cdb_valid && issue_qj_busy && (cdb_tag == issue_qj);
    assign byp_k   = cdb_valid && issue_qk_busy && (cdb_tag == issue_qk);

    always_comb begin
        free_idx = '0;
        rdy_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
            if (ready[i])   rdy_idx  = IDX_W'(i);
        end
    end

    // Free-slot choice and readiness use pre-edge state, so a slot freed by dispatch is reused one cycle later.
    always_comb begin
        busy_d      = busy_q;
        qjb_d       = qjb_q;
        qkb_d       = qkb_q;
        op_d        = op_q;
        vj_d        = vj_q;
        vk_d        = vk_q;
        qj_d        = qj_q;
        qk_d        = qk_q;
        dest_d      = dest_q;
        alu_valid_d = alu_valid_q;
        alu_op_d    = alu_op_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_dest_d  = alu_dest_q;
        if (rdy_in && flush) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
        end else if (rdy_in) begin
            alu_valid_d = has_rdy;
            if (has_rdy) begin
                alu_op_d        = op_q[rdy_idx];
                alu_op1_d       = vj_q[rdy_idx];
                alu_op2_d       = vk_q[rdy_idx];
                alu_dest_d      = dest_q[rdy_idx];
                busy_d[rdy_idx] = 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (cdb_valid && busy_q[i] && qjb_q[i] && qj_q[i] == cdb_tag) begin
                    vj_d[i]  = cdb_value;
                    qjb_d[i] = 1'b0;
                end
                if (cdb_valid && busy_q[i] && qkb_q[i] && qk_q[i] == cdb_tag) begin
                    vk_d[i]  = cdb_value;
                    qkb_d[i] = 1'b0;
                end
            end
            if (issue_valid && !rs_full) begin
                busy_d[free_idx] = 1'b0 | 1'b1;
                op_d[free_idx]   = issue_op;
                vj_d[free_idx]   = byp_j ? cdb_value : issue_vj;
                vk_d[free_idx]   = byp_k ? cdb_value : issue_vk;
                qj_d[free_idx]   = issue_qj;
                qk_d[free_idx]   = issue_qk;
                qjb_d[free_idx]  = issue_qj_busy && !byp_j;
                qkb_d[free_idx]  = issue_qk_busy && !byp_k;
                dest_d[free_idx] = issue_dest;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q      <= '0;
            qjb_q       <= '0;
            qkb_q       <= '0;
            op_q        <= '{default: '0};
            vj_q        <= '{default: '0};
            vk_q        <= '{default: '0};
            qj_q        <= '{default: '0};
            qk_q        <= '{default: '0};
            dest_q      <= '{default: '0};
            alu_valid_q <= 1'b0;
            alu_op_q    <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_dest_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            qjb_q       <= qjb_d;
            qkb_q       <= qkb_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            dest_q      <= dest_d;
            alu_valid_q <= alu_valid_d;
            alu_op_q    <= alu_op_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_dest_q  <= alu_dest_d;
        end
    end

    assign alu.alu_valid = alu_valid_q;
    assign alu.alu_op    = alu_op_q;
    assign alu.alu_op1   = alu_op1_q;
    assign alu.alu_op2   = alu_op2_q;
    assign alu.alu_dest  = alu_dest_q;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: directed stimulus with a queue scoreboard checked by an independent dispatch monitor.
module tb_rs_alu;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  d;
    } exp_t;

    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0;
    logic        issue_valid = 1'b0, issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
    logic [3:0]  issue_op = '0, issue_qj = '0, issue_qk = '0, issue_dest = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_value = '0;
    logic        rs_full;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rs_alu_if #(.TAG_W(4)) alu_if ();

    rs_alu #(.RS_SIZE(8), .TAG_W(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_busy(issue_qj_busy),
        .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_busy(issue_qk_busy),
        .issue_dest(issue_dest), .rs_full(rs_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu(alu_if)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Every dispatch strobe must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (!rst_in && alu_if.alu_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch: got op=%0h op1=%0h op2=%0h dest=%0h, required no dispatch",
                         alu_if.alu_op, alu_if.alu_op1, alu_if.alu_op2, alu_if.alu_dest);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (alu_if.alu_op !== e.op || alu_if.alu_op1 !== e.a || alu_if.alu_op2 !== e.b || alu_if.alu_dest !== e.d) begin
                    errors++;
                    $display("FAIL dispatch: got op=%0h op1=%0h op2=%0h dest=%0h, required op=%0h op1=%0h op2=%0h dest=%0h",
                             alu_if.alu_op, alu_if.alu_op1, alu_if.alu_op2, alu_if.alu_dest, e.op, e.a, e.b, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
        #1;
    endtask

    task automatic expect_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] d);
        exp_t e;
        e = '{op: op, a: a, b: b, d: d};
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj, input logic qjb,
                         input logic [31:0] vk, input logic [3:0] qk, input logic qkb, input logic [3:0] dest);
        issue_valid = 1'b1; issue_op = op;
        issue_vj = vj; issue_qj = qj; issue_qj_busy = qjb;
        issue_vk = vk; issue_qk = qk; issue_qk_busy = qkb;
        issue_dest = dest;
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
        tick();
        cdb_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst_in = 1'b0;
        chk("reset_valid", {31'b0, alu_if.alu_valid}, 32'd0);
        chk("reset_op1", alu_if.alu_op1, 32'd0);
        chk("reset_full", {31'b0, rs_full}, 32'd0);

        // both operands ready: dispatch one edge after issue
        expect_op(OP_ADD, 32'd5, 32'd7, 4'd3);
        issue(OP_ADD, 32'd5, 4'd0, 1'b0, 32'd7, 4'd0, 1'b0, 4'd3);
        chk("ready_not_yet", {31'b0, alu_if.alu_valid}, 32'd0);
        tick();
        chk("ready_valid", {31'b0, alu_if.alu_valid}, 32'd1);
        chk("ready_drained", sb.size(), 32'd0);
        tick();
        chk("ready_valid_drop", {31'b0, alu_if.alu_valid}, 32'd0);

        // CDB wakeup
        issue(OP_SUB, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 1'b0, 4'd4);
        tick();
        chk("wake_wait", {31'b0, alu_if.alu_valid}, 32'd0);
        expect_op(OP_SUB, 32'd10, 32'd1, 4'd4);
        broadcast(4'd2, 32'd10);
        chk("wake_edge_no_dispatch", {31'b0, alu_if.alu_valid}, 32'd0);
        tick();
        chk("wake_valid", {31'b0, alu_if.alu_valid}, 32'd1);
        chk("wake_drained", sb.size(), 32'd0);

        // same-cycle bypass on operand 2
        expect_op(OP_XOR, 32'd3, 32'hFFFF_0000, 4'd5);
        cdb_valid = 1'b1; cdb_tag = 4'd6; cdb_value = 32'hFFFF_0000;
        issue(OP_XOR, 32'd3, 4'd0, 1'b0, 32'hDEAD_BEEF, 4'd6, 1'b1, 4'd5);
        chk("bypass_not_yet", {31'b0, alu_if.alu_valid}, 32'd0);
        tick();
        chk("bypass_valid", {31'b0, alu_if.alu_valid}, 32'd1);
        chk("bypass_drained", sb.size(), 32'd0);
        tick();

        // fill all 8 entries, drop a 9th, then drain in index order
        for (int i = 0; i < 8; i++)
            issue(OP_ADD, 32'd0, 4'd9, 1'b1, 32'd100 + 32'(i), 4'd0, 1'b0, 4'(i));
        chk("full_set", {31'b0, rs_full}, 32'd1);
        issue(OP_SUB, 32'd0, 4'd9, 1'b1, 32'd999, 4'd0, 1'b0, 4'd15);
        chk("full_hold", {31'b0, rs_full}, 32'd1);
        for (int i = 0; i < 8; i++) expect_op(OP_ADD, 32'h50, 32'd100 + 32'(i), 4'(i));
        broadcast(4'd9, 32'h50);
        chk("full_wake_edge", {31'b0, alu_if.alu_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("full_consecutive", {31'b0, alu_if.alu_valid}, 32'd1);
        end
        chk("full_clear", {31'b0, rs_full}, 32'd0);
        chk("full_drained", sb.size(), 32'd0);
        tick();
        tick();
        chk("full_idle", {31'b0, alu_if.alu_valid}, 32'd0);

        // stall: a broadcast while frozen is missed
        issue(OP_AND, 32'd0, 4'd11, 1'b1, 32'd2, 4'd0, 1'b0, 4'd7);
        rdy_in = 1'b0;
        broadcast(4'd11, 32'd77);
        rdy_in = 1'b1;
        tick();
        tick();
        chk("stall_no_wake", {31'b0, alu_if.alu_valid}, 32'd0);
        expect_op(OP_AND, 32'd88, 32'd2, 4'd7);
        broadcast(4'd11, 32'd88);
        tick();
        chk("stall_resume_valid", {31'b0, alu_if.alu_valid}, 32'd1);
        chk("stall_drained", sb.size(), 32'd0);

        // flush: four waiting plus one ready entry, with concurrent issue and CDB ignored
        for (int i = 0; i < 4; i++)
            issue(OP_OR, 32'd0, 4'd12, 1'b1, 32'd1, 4'd0, 1'b0, 4'(8 + i));
        issue(OP_OR, 32'd1, 4'd0, 1'b0, 32'd2, 4'd0, 1'b0, 4'd14);
        flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4'd12; cdb_value = 32'd5;
        issue(OP_ADD, 32'd9, 4'd0, 1'b0, 32'd9, 4'd0, 1'b0, 4'd1);
        flush = 1'b0;
        chk("flush_valid", {31'b0, alu_if.alu_valid}, 32'd0);
        chk("flush_full", {31'b0, rs_full}, 32'd0);
        broadcast(4'd12, 32'd6);
        tick();
        tick();
        chk("flush_no_dispatch", {31'b0, alu_if.alu_valid}, 32'd0);
        expect_op(OP_OR, 32'h1234_5678, 32'h0F, 4'd13);
        issue(OP_OR, 32'h1234_5678, 4'd0, 1'b0, 32'h0F, 4'd0, 1'b0, 4'd13);
        tick();
        chk("post_flush_valid", {31'b0, alu_if.alu_valid}, 32'd1);
        chk("post_flush_drained", sb.size(), 32'd0);

        // asynchronous reset with three busy entries and nonzero outputs
        for (int i = 0; i < 3; i++)
            issue(OP_SUB, 32'd0, 4'd13, 1'b1, 32'd3, 4'd0, 1'b0, 4'(i));
        #1 rst_in = 1'b1;
        #1;
        chk("async_op1", alu_if.alu_op1, 32'd0);
        chk("async_op2", alu_if.alu_op2, 32'd0);
        chk("async_dest", {28'b0, alu_if.alu_dest}, 32'd0);
        chk("async_op", {28'b0, alu_if.alu_op}, 32'd0);
        chk("async_full", {31'b0, rs_full}, 32'd0);
        tick();
        rst_in = 1'b0;
        broadcast(4'd13, 32'd44);
        tick();
        tick();
        chk("post_reset_idle", {31'b0, alu_if.alu_valid}, 32'd0);
        chk("final_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
